// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master engine between NUM_REQ requesters.
// Latches the winner's descriptor, launches it, routes data/status and enforces a watchdog.
module i2c_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int LEN_W          = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [7*NUM_REQ-1:0]     i_req_dev_addr,
  input  logic [8*NUM_REQ-1:0]     i_req_reg_addr,
  input  logic [NUM_REQ-1:0]       i_req_rw,
  input  logic [LEN_W*NUM_REQ-1:0] i_req_len,
  input  logic [8*NUM_REQ-1:0]     i_req_wdata,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic [NUM_REQ-1:0]       o_wdata_ack,
  output logic [7:0]               o_rdata,
  output logic [NUM_REQ-1:0]       o_rdata_valid,
  output logic [NUM_REQ-1:0]       o_done,
  output logic [NUM_REQ-1:0]       o_err,
  output logic                     o_m_start,
  output logic [6:0]               o_m_dev_addr,
  output logic [7:0]               o_m_reg_addr,
  output logic                     o_m_rw,
  output logic [LEN_W-1:0]         o_m_len,
  output logic [7:0]               o_m_wdata,
  input  logic                     i_m_wdata_req,
  input  logic [7:0]               i_m_rdata,
  input  logic                     i_m_rdata_valid,
  input  logic                     i_m_done,
  input  logic                     i_m_nack,
  output logic                     o_m_abort,
  input  logic                     i_m_busy
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_LAUNCH, S_XFER, S_FINISH} state_t;
  state_t r_state, w_next;

  logic [IDX_W-1:0]   r_ptr, w_win, w_k;
  logic               w_found;
  logic [6:0]         w_dev;
  logic [7:0]         w_reg, w_wdata;
  logic               w_rw;
  logic [LEN_W-1:0]   w_len;
  logic [NUM_REQ-1:0] r_gnt, r_done, r_err, r_rdata_valid;
  logic [7:0]         r_rdata;
  logic               r_abort;
  logic [WD_W-1:0]    r_wd;
  logic               w_wd_exp;

  // First asserted request at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_k = (int'(r_ptr) + i >= NUM_REQ) ? IDX_W'(int'(r_ptr) + i - NUM_REQ)
                                         : IDX_W'(int'(r_ptr) + i);
      if (!w_found && i_req[w_k]) begin
        w_found = 1'b1;
        w_win   = w_k;
      end
    end
  end

  always_comb begin
    w_dev   = '0;
    w_reg   = '0;
    w_rw    = 1'b0;
    w_len   = '0;
    w_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IDX_W'(i)) begin
        w_dev = i_req_dev_addr[7*i +: 7];
        w_reg = i_req_reg_addr[8*i +: 8];
        w_rw  = i_req_rw[i];
        w_len = i_req_len[LEN_W*i +: LEN_W];
      end
      if (r_gnt[i]) w_wdata = i_req_wdata[8*i +: 8];
    end
  end

  assign w_wd_exp = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (|i_req && !i_m_busy) w_next = S_ARB;
      S_ARB:    if (!w_found)            w_next = S_IDLE;
                else if (w_len == '0)    w_next = S_FINISH;
                else                     w_next = S_LAUNCH;
      S_LAUNCH:                          w_next = S_XFER;
      S_XFER:   if (i_m_done || i_m_nack || w_wd_exp) w_next = S_FINISH;
      S_FINISH:                          w_next = S_IDLE;
      default:                           w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_gnt         <= '0;
      r_done        <= '0;
      r_err         <= '0;
      r_rdata_valid <= '0;
      r_rdata       <= '0;
      r_abort       <= 1'b0;
      r_wd          <= '0;
      o_m_dev_addr  <= '0;
      o_m_reg_addr  <= '0;
      o_m_rw        <= 1'b0;
      o_m_len       <= '0;
    end else begin
      r_state       <= w_next;
      r_done        <= '0;
      r_err         <= '0;
      r_rdata_valid <= '0;
      r_abort       <= 1'b0;
      case (r_state)
        S_ARB: if (w_found) begin
          r_gnt        <= NUM_REQ'(1) << w_win;
          r_ptr        <= (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
          o_m_dev_addr <= w_dev;
          o_m_reg_addr <= w_reg;
          o_m_rw       <= w_rw;
          o_m_len      <= w_len;
          if (w_len == '0) r_err <= NUM_REQ'(1) << w_win;
        end
        S_LAUNCH: r_wd <= '0;
        S_XFER: begin
          r_wd <= r_wd + 1'b1;
          if (i_m_rdata_valid) begin
            r_rdata       <= i_m_rdata;
            r_rdata_valid <= r_gnt;
          end
          // Master status beats the watchdog; NACK beats done.
          if (i_m_nack)      r_err  <= r_gnt;
          else if (i_m_done) r_done <= r_gnt;
          else if (w_wd_exp) begin
            r_err   <= r_gnt;
            r_abort <= 1'b1;
          end
        end
        S_FINISH: r_gnt <= '0;
        default: ;
      endcase
    end
  end

  assign o_gnt         = r_gnt;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_rdata_valid = r_rdata_valid;
  assign o_rdata       = r_rdata;
  assign o_m_abort     = r_abort;
  assign o_m_start     = (r_state == S_LAUNCH);
  assign o_m_wdata     = w_wdata;
  assign o_wdata_ack   = (r_state == S_XFER && i_m_wdata_req) ? r_gnt : '0;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: stimulus pushes expected events, a negedge monitor pops them.
module tb_i2c_bus_arbiter;
  localparam int K_START = 0, K_WACK = 1, K_RDV = 2, K_DONE = 3, K_ERR = 4, K_ABORT = 5;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  req = '0, req_rw = '0;
  logic [13:0] req_dev_addr = '0;
  logic [15:0] req_reg_addr = '0, req_wdata = '0;
  logic [7:0]  req_len = '0;
  logic [1:0]  gnt, wdata_ack, rdata_valid, done, err;
  logic [7:0]  rdata, m_reg_addr, m_wdata;
  logic [6:0]  m_dev_addr;
  logic [3:0]  m_len;
  logic        m_start, m_rw, m_abort;
  logic        m_wdata_req = 0, m_rdata_valid = 0, m_done = 0, m_nack = 0, m_busy = 0;
  logic [7:0]  m_rdata = '0;

  typedef struct {int kind; int idx; int data; int cyc;} exp_t;
  exp_t q[$];
  int vectors = 0, fails = 0, cyc = 0, s, c0;

  i2c_bus_arbiter #(.NUM_REQ(2), .LEN_W(4), .TIMEOUT_CYCLES(50)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_dev_addr(req_dev_addr),
    .i_req_reg_addr(req_reg_addr), .i_req_rw(req_rw), .i_req_len(req_len),
    .i_req_wdata(req_wdata), .o_gnt(gnt), .o_wdata_ack(wdata_ack), .o_rdata(rdata),
    .o_rdata_valid(rdata_valid), .o_done(done), .o_err(err), .o_m_start(m_start),
    .o_m_dev_addr(m_dev_addr), .o_m_reg_addr(m_reg_addr), .o_m_rw(m_rw), .o_m_len(m_len),
    .o_m_wdata(m_wdata), .i_m_wdata_req(m_wdata_req), .i_m_rdata(m_rdata),
    .i_m_rdata_valid(m_rdata_valid), .i_m_done(m_done), .i_m_nack(m_nack),
    .o_m_abort(m_abort), .i_m_busy(m_busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int desc(input logic [6:0] dev, input logic [7:0] ra, input logic rw,
                              input logic [3:0] len);
    return int'({dev, ra, rw, len});
  endfunction

  function automatic int idx_of(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe(input int kind, input int idx, input int data);
    exp_t e;
    vectors++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: kind %0d idx %0d data %0h at cycle %0d, nothing expected",
               kind, idx, data, cyc);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.idx != idx || e.data != data || (e.cyc >= 0 && e.cyc != cyc)) begin
      fails++;
      $display("FAIL event: got kind %0d idx %0d data %0h cyc %0d, expected kind %0d idx %0d data %0h cyc %0d",
               kind, idx, data, cyc, e.kind, e.idx, e.data, e.cyc);
    end
  endtask

  // Monitor: every DUT pulse must match the next expected event.
  always @(negedge clk) if (rst_n) begin
    chk("gnt_onehot0", int'($onehot0(gnt)), 1);
    if (m_start)       observe(K_START, idx_of(gnt), int'({m_dev_addr, m_reg_addr, m_rw, m_len}));
    if (|wdata_ack)    observe(K_WACK, idx_of(wdata_ack), int'(m_wdata));
    if (|rdata_valid)  observe(K_RDV, idx_of(rdata_valid), int'(rdata));
    if (|done)         observe(K_DONE, idx_of(done), 0);
    if (|err)          observe(K_ERR, idx_of(err), 0);
    if (m_abort)       observe(K_ABORT, idx_of(gnt), 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input int i, input int d, input int c);
    q.push_back('{k, i, d, c});
  endtask

  task automatic set_desc(input int i, input logic [6:0] dev, input logic [7:0] ra,
                          input logic rw, input logic [3:0] len, input logic [7:0] wd);
    req_dev_addr[7*i +: 7] = dev;
    req_reg_addr[8*i +: 8] = ra;
    req_rw[i]              = rw;
    req_len[4*i +: 4]      = len;
    req_wdata[8*i +: 8]    = wd;
  endtask

  task automatic wait_start(output int st);
    st = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_start) begin
        st = cyc;
        return;
      end
    end
    chk("m_start_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_status", int'({done, err, rdata_valid, wdata_ack}), 0);
    chk("rst_m_start_abort", int'({m_start, m_abort}), 0);
    chk("rst_rdata", int'(rdata), 0);
    chk("rst_desc", int'({m_dev_addr, m_reg_addr, m_rw, m_len}), 0);
    rst_n = 1'b1;
    step();

    // Single read, 6 bytes, owner 0
    set_desc(0, 7'h68, 8'h3B, 1'b1, 4'd6, 8'h00);
    c0 = cyc;
    push(K_START, 0, desc(7'h68, 8'h3B, 1'b1, 4'd6), c0 + 2);
    req = 2'b01;
    wait_start(s);
    for (int b = 1; b <= 6; b++) begin
      step();
      m_rdata = 8'(b); m_rdata_valid = 1'b1;
      push(K_RDV, 0, b, -1);
    end
    step();
    m_rdata_valid = 1'b0; m_done = 1'b1;
    push(K_DONE, 0, 0, -1);
    step();
    m_done = 1'b0; req = 2'b00;
    chk("gnt_in_finish", int'(gnt), 1);
    step();
    chk("gnt_after_finish", int'(gnt), 0);

    // Write, 2 bytes, owner 1
    set_desc(1, 7'h1E, 8'h10, 1'b0, 4'd2, 8'hAA);
    push(K_START, 1, desc(7'h1E, 8'h10, 1'b0, 4'd2), -1);
    req = 2'b10;
    wait_start(s);
    step();
    m_wdata_req = 1'b1;
    push(K_WACK, 1, 8'hAA, -1);
    step();
    req_wdata[15:8] = 8'h55;
    push(K_WACK, 1, 8'h55, -1);
    step();
    m_wdata_req = 1'b0; m_done = 1'b1;
    push(K_DONE, 1, 0, -1);
    step();
    m_done = 1'b0; req = 2'b00;
    step();

    // Contention, pointer at 0: owners 0,1,0,1
    set_desc(0, 7'h11, 8'h01, 1'b1, 4'd1, 8'h00);
    set_desc(1, 7'h22, 8'h02, 1'b0, 4'd1, 8'h33);
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      push(K_START, t % 2, (t % 2 == 0) ? desc(7'h11, 8'h01, 1'b1, 4'd1)
                                        : desc(7'h22, 8'h02, 1'b0, 4'd1), -1);
      wait_start(s);
      step();
      m_done = 1'b1;
      push(K_DONE, t % 2, 0, -1);
      step();
      m_done = 1'b0;
      if (t == 3) req = 2'b00;
    end
    step();

    // NACK on owner 0, then a normal write on owner 1
    set_desc(0, 7'h50, 8'h20, 1'b1, 4'd3, 8'h00);
    push(K_START, 0, desc(7'h50, 8'h20, 1'b1, 4'd3), -1);
    req = 2'b01;
    wait_start(s);
    step();
    step();
    m_nack = 1'b1;
    push(K_ERR, 0, 0, -1);
    step();
    m_nack = 1'b0; req = 2'b00;
    step();
    set_desc(1, 7'h2A, 8'h07, 1'b0, 4'd1, 8'h9C);
    push(K_START, 1, desc(7'h2A, 8'h07, 1'b0, 4'd1), -1);
    req = 2'b10;
    wait_start(s);
    step();
    m_wdata_req = 1'b1;
    push(K_WACK, 1, 8'h9C, -1);
    step();
    m_wdata_req = 1'b0; m_done = 1'b1;
    push(K_DONE, 1, 0, -1);
    step();
    m_done = 1'b0; req = 2'b00;
    step();

    // Watchdog: silent master, abort + err after XFER cycles 0..49
    set_desc(0, 7'h0C, 8'h44, 1'b1, 4'd1, 8'h00);
    push(K_START, 0, desc(7'h0C, 8'h44, 1'b1, 4'd1), -1);
    req = 2'b01;
    wait_start(s);
    push(K_ERR, 0, 0, s + 51);
    push(K_ABORT, 0, 0, s + 51);
    repeat (51) step();
    req = 2'b00;
    step();

    // Completion in the expiry cycle: done only, no abort
    push(K_START, 0, desc(7'h0C, 8'h44, 1'b1, 4'd1), -1);
    req = 2'b01;
    wait_start(s);
    repeat (50) step();
    m_done = 1'b1;
    push(K_DONE, 0, 0, s + 51);
    step();
    m_done = 1'b0; req = 2'b00;
    step();

    // Zero length: err two cycles after request, no m_start
    set_desc(1, 7'h33, 8'h55, 1'b0, 4'd0, 8'h01);
    c0 = cyc;
    push(K_ERR, 1, 0, c0 + 2);
    req = 2'b10;
    step();
    step();
    req = 2'b00;
    step();
    step();

    // Reset mid-XFER
    set_desc(0, 7'h68, 8'h75, 1'b1, 4'd4, 8'hC3);
    push(K_START, 0, desc(7'h68, 8'h75, 1'b1, 4'd4), -1);
    req = 2'b01;
    wait_start(s);
    step();
    m_rdata = 8'h77; m_rdata_valid = 1'b1;
    push(K_RDV, 0, 8'h77, -1);
    step();
    m_rdata_valid = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_gnt", int'(gnt), 0);
    chk("arst_status", int'({done, err, rdata_valid, wdata_ack}), 0);
    chk("arst_m_start_abort", int'({m_start, m_abort}), 0);
    chk("arst_rdata", int'(rdata), 0);
    chk("arst_m_wdata", int'(m_wdata), 0);
    chk("arst_desc", int'({m_dev_addr, m_reg_addr, m_rw, m_len}), 0);
    req = 2'b00;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Pointer back at 0: both requesting, owner 0 wins
    set_desc(1, 7'h22, 8'h02, 1'b0, 4'd1, 8'h33);
    push(K_START, 0, desc(7'h68, 8'h75, 1'b1, 4'd4), -1);
    req = 2'b11;
    wait_start(s);
    step();
    m_done = 1'b1;
    push(K_DONE, 0, 0, -1);
    step();
    m_done = 1'b0; req = 2'b00;
    step();
    step();

    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
